uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised successor to the team's fixed 8-bit UART transmitter. It adds configurable data width, a runtime baud prescaler, and one or two stop bits. A small input FIFO lets the upstream block queue several words, which are then sent back-to-back with no idle gap. It sits between the system controller / register file and the serial line, on the same clock as the rest of the low-power comm datapath.

Parameters:
WIDTH, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, input FIFO entries; must be a power of 2, at least 2.
PRESCALE_W, 6, width of the Prescale input (clocks per bit).

Ports:
CLK  input  1  system clock; all logic is on its rising edge.
Reset  input  1  synchronous, active-low reset.
Prescale  input  PRESCALE_W  clock cycles per serial bit; 0 is treated as 1.
Parity_EN  input  1  1 = insert a parity bit.
Parity_type  input  1  0 = even parity, 1 = odd parity.
Stop2  input  1  1 = two stop bits, 0 = one stop bit.
Data_valid  input  1  write strobe into the FIFO.
Data  input  WIDTH  word to transmit.
Ready  output  1  FIFO not full; a write is accepted only when Data_valid=1 and Ready=1.
Busy  output  1  a frame is on the line.
Tx_out  output  1  serial output; idles high.
Fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words stored in the FIFO.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - Tx_out=1, Busy=0, Ready=1, Fifo_count=0.
  - FIFO pointers and FSM cleared to IDLE; bit and prescale counters cleared.
  - Applies mid-frame too: the frame is aborted and the line goes high at that edge; queued words are discarded.
- FIFO:
  - Write when Data_valid & Ready. Pop is issued only by the FSM.
  - Write and pop in the same cycle: count unchanged.
  - When full, Ready=0 even if a pop occurs in the same cycle. The rejected word is dropped with no error flag.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE -> START when Fifo_count>0. On that edge the FSM pops the head word and latches it, together with Parity_EN, Parity_type, Stop2 and Prescale (effective value P = max(Prescale,1)).
  - Config inputs are sampled only at frame start; changing them mid-frame has no effect on that frame.
  - START: Tx_out=0 for P cycles -> DATA.
  - DATA: WIDTH bits, LSB first, P cycles each -> PARITY if parity was latched enabled, else STOP.
  - PARITY: P cycles. Value = XOR of the data bits, inverted when odd parity is selected -> STOP.
  - STOP: Tx_out=1 for P cycles, or 2P cycles when Stop2 was latched -> START with a new pop if the FIFO is non-empty, else IDLE.
- Timing:
  - Tx_out and Busy are registered.
  - A word written at edge k into an empty FIFO with the FSM in IDLE: Tx_out=0 and Busy=1 from edge k+1.
  - Frame length in cycles = P × (1 + WIDTH + Parity_EN + 1 + Stop2).
  - Busy stays high continuously across back-to-back frames; it falls at the edge ending the last stop bit when the FIFO is empty.
- The prescale counter counts 0..P-1 and advances the bit at P-1. Its width is PRESCALE_W; it never overflows because P ≤ 2^PRESCALE_W − 1.

Test Plan:
- Basic frame: WIDTH=8, Prescale=1, Parity_EN=1, even parity, one stop bit, write 0x55 -> Tx_out sequence 0,1,0,1,0,1,0,1,0,0(parity),1; Busy high exactly 11 cycles starting one edge after the write.
- Odd parity with 2 stop bits: write 0xAA, Parity_type=1, Stop2=1, Prescale=4 -> parity bit 1, each bit held 4 cycles, Busy high 48 cycles, then Tx_out=1 and Busy=0.
- Full-FIFO behaviour: FIFO_DEPTH=4, Prescale=8, write 6 words on consecutive cycles -> 5 accepted (first popped immediately), Ready=0 from the 5th write, 6th dropped, Fifo_count peaks at 4; all 5 words sent with no idle cycle between frames.
- Mid-frame config change: Parity_EN=0 and Prescale=2 at frame start, change to Parity_EN=1 and Prescale=5 during DATA -> current frame is 10 bits × 2 cycles; the next queued frame uses 11 bits × 5 cycles.
- Reset during DATA with 2 words queued: Reset=0 for one edge -> Tx_out=1, Busy=0, Fifo_count=0 at that edge, and no further frames are sent.
- Prescale=0 and WIDTH=5 build: write 0x1F with parity disabled -> frame 0,1,1,1,1,1,1, one cycle per bit.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, runtime prescaler, optional parity
// and one or two stop bits. Queued words are sent back-to-back.
module uart_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 6
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic [PRESCALE_W-1:0]         Prescale,
  input  logic                          Parity_EN,
  input  logic                          Parity_type,
  input  logic                          Stop2,
  input  logic                          Data_valid,
  input  logic [WIDTH-1:0]              Data,
  output logic                          Ready,
  output logic                          Busy,
  output logic                          Tx_out,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  wr_en;
  logic                  pop;
  logic                  load;
  logic [WIDTH-1:0]      head;

  state_t                state_q;
  state_t                state_d;
  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;
  logic [PRESCALE_W-1:0] p_q;
  logic [BW-1:0]         bit_q;
  logic [BW-1:0]         bit_d;
  logic [WIDTH-1:0]      shift_q;
  logic [WIDTH-1:0]      shift_d;
  logic                  par_en_q;
  logic                  parity_q;
  logic                  stop2_q;
  logic                  tx_q;
  logic                  tx_d;
  logic                  busy_q;
  logic                  bit_end;

  // Ready depends only on the stored count, so a full FIFO refuses a write
  // even when the FSM pops in the same cycle.
  assign Ready      = (count != FULL);
  assign wr_en      = Data_valid & Ready;
  assign Fifo_count = count;
  assign head       = mem[rd_ptr];
  assign Tx_out     = tx_q;
  assign Busy       = busy_q;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= Data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bit_end = (presc_q == p_q - 1'b1);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    load    = 1'b0;
    if (state_q != IDLE) begin
      presc_d = bit_end ? '0 : presc_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          load    = 1'b1;
          presc_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        // bit_q counts stop bits so a second stop period can follow the first
        if (bit_end) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_d = BW'(1);
          end else if (count != '0) begin
            pop     = 1'b1;
            load    = 1'b1;
            bit_d   = '0;
            state_d = START;
          end else begin
            bit_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Frame configuration is captured together with the popped word.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      p_q      <= PRESCALE_W'(1);
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      if (load) begin
        shift_q  <= head;
        parity_q <= (^head) ^ Parity_type;
        par_en_q <= Parity_EN;
        stop2_q  <= Stop2;
        p_q      <= (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
      end else begin
        shift_q <= shift_d;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a monitor
// decodes the serial line and compares. A second WIDTH=5 instance covers Prescale=0.
module tb_uart_tx_fifo;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Prescale = 6'd1;
  logic       Parity_EN = 1'b0;
  logic       Parity_type = 1'b0;
  logic       Stop2 = 1'b0;
  logic       Data_valid = 1'b0;
  logic [7:0] Data = 8'h00;
  logic       Ready;
  logic       Busy;
  logic       Tx_out;
  logic [2:0] Fifo_count;

  logic [5:0] d5_prescale = 6'd0;
  logic       d5_valid = 1'b0;
  logic [4:0] d5_data = 5'h00;
  logic       d5_ready;
  logic       d5_busy;
  logic       d5_tx;
  logic [2:0] d5_count;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b1;
  bit in_frame = 1'b0;
  string exp_bits_q[$];
  int exp_p_q[$];

  always #5 CLK = ~CLK;

  uart_tx_fifo #(.WIDTH(8), .FIFO_DEPTH(4), .PRESCALE_W(6)) dut (
    .CLK(CLK), .Reset(Reset), .Prescale(Prescale), .Parity_EN(Parity_EN),
    .Parity_type(Parity_type), .Stop2(Stop2), .Data_valid(Data_valid),
    .Data(Data), .Ready(Ready), .Busy(Busy), .Tx_out(Tx_out),
    .Fifo_count(Fifo_count)
  );

  uart_tx_fifo #(.WIDTH(5), .FIFO_DEPTH(4), .PRESCALE_W(6)) dut5 (
    .CLK(CLK), .Reset(Reset), .Prescale(d5_prescale), .Parity_EN(1'b0),
    .Parity_type(1'b0), .Stop2(1'b0), .Data_valid(d5_valid),
    .Data(d5_data), .Ready(d5_ready), .Busy(d5_busy), .Tx_out(d5_tx),
    .Fifo_count(d5_count)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_string(input string name, input string actual, input string expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %s, expected %s", name, actual, expected);
    end
  endtask

  // Drives one write strobe; the expected frame is queued before the edge.
  task automatic apply_stimulus(input logic [7:0] word, input string bits, input int p,
                                input bit push, output int rdy, output int cnt);
    @(negedge CLK);
    Data_valid = 1'b1;
    Data = word;
    if (push) begin
      exp_bits_q.push_back(bits);
      exp_p_q.push_back(p);
    end
    @(posedge CLK);
    #1;
    Data_valid = 1'b0;
    rdy = Ready;
    cnt = Fifo_count;
  endtask

  task automatic measure_busy(input int limit, output int len);
    int waited = 0;
    len = 0;
    @(negedge CLK);
    while (!Busy && waited < limit) begin
      @(negedge CLK);
      waited++;
    end
    while (Busy && len < limit) begin
      len++;
      @(negedge CLK);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while ((Busy || in_frame || exp_bits_q.size() != 0) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (n >= limit) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: timeout waiting for idle, queued=%0d required 0",
               name, exp_bits_q.size());
    end
  endtask

  // Monitor: samples each bit's first cycle and checks it holds for P cycles.
  initial begin
    string obs;
    string cur_bits;
    string one = "1";
    string zero = "0";
    int cur_p;
    bit first;
    bit hold_ok;
    forever begin
      @(negedge CLK);
      if (mon_en && Busy) begin
        if (exp_bits_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_frame: got busy line, expected idle");
          for (int i = 0; i < 1000 && Busy; i++) @(negedge CLK);
        end else begin
          in_frame = 1'b1;
          cur_bits = exp_bits_q.pop_front();
          cur_p = exp_p_q.pop_front();
          obs = "";
          hold_ok = 1'b1;
          first = 1'b1;
          for (int b = 0; b < cur_bits.len(); b++) begin
            for (int c = 0; c < cur_p; c++) begin
              if (b != 0 || c != 0) @(negedge CLK);
              if (c == 0) begin
                first = Tx_out;
                obs = {obs, Tx_out ? one : zero};
              end else if (Tx_out !== first) begin
                hold_ok = 1'b0;
              end
              if (Busy !== 1'b1) hold_ok = 1'b0;
            end
          end
          check_string("frame_bits", obs, cur_bits);
          check_output("frame_hold_busy", int'(hold_ok), 1);
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rdy;
    int cnt;
    int len;
    int busy_seen;
    int tx_low_seen;
    string obs5;

    repeat (3) @(posedge CLK);
    #1;
    check_output("reset_tx", Tx_out, 1);
    check_output("reset_busy", Busy, 0);
    check_output("reset_ready", Ready, 1);
    check_output("reset_count", Fifo_count, 0);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] basic frame 0x55, even parity, P=1");
    Prescale = 6'd1; Parity_EN = 1'b1; Parity_type = 1'b0; Stop2 = 1'b0;
    fork
      apply_stimulus(8'h55, "01010101001", 1, 1'b1, rdy, cnt);
      measure_busy(200, len);
    join
    check_output("basic_busy_len", len, 11);
    wait_idle("basic", 200);
    check_output("basic_idle_tx", Tx_out, 1);

    $display("[TB] odd parity, two stop bits, 0xAA, P=4");
    Prescale = 6'd4; Parity_EN = 1'b1; Parity_type = 1'b1; Stop2 = 1'b1;
    fork
      apply_stimulus(8'hAA, "001010101111", 4, 1'b1, rdy, cnt);
      measure_busy(400, len);
    join
    check_output("odd_busy_len", len, 48);
    wait_idle("odd", 400);
    check_output("odd_idle_tx", Tx_out, 1);
    check_output("odd_idle_busy", Busy, 0);

    $display("[TB] mid-frame config change");
    Prescale = 6'd2; Parity_EN = 1'b0; Parity_type = 1'b0; Stop2 = 1'b0;
    fork
      begin
        apply_stimulus(8'h0F, "0111100001", 2, 1'b1, rdy, cnt);
        apply_stimulus(8'h3C, "00011110001", 5, 1'b1, rdy, cnt);
        repeat (6) @(negedge CLK);
        Parity_EN = 1'b1;
        Prescale = 6'd5;
      end
      measure_busy(400, len);
    join
    check_output("cfg_busy_len", len, 75);
    wait_idle("cfg", 400);

    $display("[TB] full FIFO, P=8");
    Prescale = 6'd8; Parity_EN = 1'b0; Parity_type = 1'b0; Stop2 = 1'b0;
    fork
      begin
        apply_stimulus(8'h01, "0100000001", 8, 1'b1, rdy, cnt);
        check_output("full_count_w1", cnt, 1);
        apply_stimulus(8'h02, "0010000001", 8, 1'b1, rdy, cnt);
        check_output("full_count_w2", cnt, 1);
        apply_stimulus(8'h03, "0110000001", 8, 1'b1, rdy, cnt);
        apply_stimulus(8'h04, "0001000001", 8, 1'b1, rdy, cnt);
        check_output("full_ready_w4", rdy, 1);
        check_output("full_count_w4", cnt, 3);
        apply_stimulus(8'h05, "0101000001", 8, 1'b1, rdy, cnt);
        check_output("full_ready_w5", rdy, 0);
        check_output("full_count_w5", cnt, 4);
        apply_stimulus(8'h06, "", 8, 1'b0, rdy, cnt);
        check_output("full_ready_w6", rdy, 0);
        check_output("full_count_w6", cnt, 4);
      end
      measure_busy(1000, len);
    join
    check_output("full_busy_len", len, 400);
    wait_idle("full", 1000);
    check_output("full_count_end", Fifo_count, 0);

    $display("[TB] reset during DATA with two words queued");
    mon_en = 1'b0;
    Prescale = 6'd4; Parity_EN = 1'b0; Stop2 = 1'b0;
    apply_stimulus(8'hC3, "", 4, 1'b0, rdy, cnt);
    apply_stimulus(8'h5A, "", 4, 1'b0, rdy, cnt);
    apply_stimulus(8'hA5, "", 4, 1'b0, rdy, cnt);
    check_output("rst_count_before", cnt, 2);
    repeat (6) @(negedge CLK);
    check_output("rst_busy_before", Busy, 1);
    Reset = 1'b0;
    @(posedge CLK);
    #1;
    check_output("rst_tx", Tx_out, 1);
    check_output("rst_busy", Busy, 0);
    check_output("rst_count", Fifo_count, 0);
    check_output("rst_ready", Ready, 1);
    @(negedge CLK);
    Reset = 1'b1;
    busy_seen = 0;
    tx_low_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (Busy) busy_seen++;
      if (!Tx_out) tx_low_seen++;
    end
    check_output("rst_no_frames_busy", busy_seen, 0);
    check_output("rst_no_frames_tx", tx_low_seen, 0);

    $display("[TB] WIDTH=5 build, Prescale=0, 0x1F");
    @(negedge CLK);
    d5_valid = 1'b1;
    d5_data = 5'h1F;
    @(posedge CLK);
    #1;
    d5_valid = 1'b0;
    obs5 = "";
    len = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (d5_busy) begin
        len++;
        obs5 = {obs5, d5_tx ? "1" : "0"};
      end else if (len != 0) begin
        break;
      end
    end
    check_string("w5_frame_bits", obs5, "0111111");
    check_output("w5_busy_len", len, 7);
    check_output("w5_idle_tx", d5_tx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
